// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: operation codes and FSM states.
package usr_pkg;

    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_ROL = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-step shifter: computes the register value after one step of op.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             ser_in_left,
    input  logic             ser_in_right,
    output logic [WIDTH-1:0] next_q
);

    logic             left_fill;
    logic             right_fill;
    logic [WIDTH-1:0] shl_q;
    logic [WIDTH-1:0] shr_q;

    // Every left-moving op differs only in the bit entering the LSB; right-moving ops likewise for the MSB.
    always_comb begin
        left_fill = ser_in_right;
        if (op == OP_ROL) begin
            left_fill = q[WIDTH-1];
        end

        right_fill = ser_in_left;
        if (op == OP_ROR) begin
            right_fill = q[0];
        end else if (op == OP_ASR) begin
            right_fill = q[WIDTH-1];
        end
    end

    // Loops rather than part-selects so that WIDTH==1 degenerates to just the fill bit.
    always_comb begin
        shl_q    = '0;
        shl_q[0] = left_fill;
        for (int i = 1; i < WIDTH; i++) begin
            shl_q[i] = q[i-1];
        end

        shr_q          = '0;
        shr_q[WIDTH-1] = right_fill;
        for (int i = 0; i < WIDTH - 1; i++) begin
            shr_q[i] = q[i+1];
        end
    end

    always_comb begin
        next_q = q;
        case (op)
            OP_SHL, OP_ROL:         next_q = shl_q;
            OP_SHR, OP_ROR, OP_ASR: next_q = shr_q;
            default:                next_q = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit register with parallel load and a multi-cycle shift/rotate engine (one bit per clock)
// signalled through a busy/done handshake.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic             ser_in_left,
    input  logic             ser_in_right,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             busy,
    output logic             done
);

    state_t           state, state_next;
    logic [AMT_W-1:0] counter, counter_next;
    logic [2:0]       op_reg, op_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] step_q;
    logic             done_next;

    usr_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q           (q),
        .op          (op_reg),
        .ser_in_left (ser_in_left),
        .ser_in_right(ser_in_right),
        .next_q      (step_q)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_IDLE;
            counter <= '0;
            op_reg  <= OP_SHL;
            q       <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            op_reg  <= op_next;
            q       <= q_next;
            done    <= done_next;
        end
    end

    // load and start are only honoured in IDLE, so a running shift can never be disturbed.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        op_next      = op_reg;
        q_next       = q;
        done_next    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    q_next = d;
                end else if (start) begin
                    if (amount == '0) begin
                        done_next = 1'b1;
                    end else begin
                        op_next      = op;
                        counter_next = amount;
                        state_next   = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                q_next       = step_q;
                counter_next = counter - AMT_W'(1);
                if (counter == AMT_W'(1)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SHIFT);
    end

    assign ser_out_msb = q[WIDTH-1];
    assign ser_out_lsb = q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8): arithmetic reference model checked
// every cycle, plus directed scenarios with hand-computed results.
module tb_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] d;
    logic             load;
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amount;
    logic             ser_in_left;
    logic             ser_in_right;
    logic [WIDTH-1:0] q;
    logic             ser_out_msb;
    logic             ser_out_lsb;
    logic             busy;
    logic             done;

    int tests_run    = 0;
    int tests_failed = 0;

    universal_shift_register #(
        .WIDTH(WIDTH),
        .AMT_W(AMT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .d           (d),
        .load        (load),
        .start       (start),
        .op          (op),
        .amount      (amount),
        .ser_in_left (ser_in_left),
        .ser_in_right(ser_in_right),
        .q           (q),
        .ser_out_msb (ser_out_msb),
        .ser_out_lsb (ser_out_lsb),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: plain arithmetic on the value, a remaining-steps count and a busy flag.
    bit         m_valid = 1'b0;
    bit         m_busy;
    bit         m_done;
    int         m_left;
    logic [2:0] m_op;
    logic [7:0] m_q;

    function automatic logic [7:0] modelStep(input logic [7:0] v, input logic [2:0] o,
                                             input logic sl, input logic sr);
        int t;
        t = int'(v);
        case (o)
            3'd0:    return 8'((t * 2 + int'(sr)) % 256);
            3'd1:    return 8'(t / 2 + (sl ? 128 : 0));
            3'd2:    return 8'((t * 2) % 256 + t / 128);
            3'd3:    return 8'(t / 2 + (t % 2) * 128);
            3'd4:    return 8'(t / 2 + (t >= 128 ? 128 : 0));
            default: return v;
        endcase
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            m_q     = 8'h00;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_left  = 0;
            m_op    = 3'd0;
            m_valid = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_q = modelStep(m_q, m_op, ser_in_left, ser_in_right);
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (load) begin
                m_q = d;
            end else if (start) begin
                if (amount == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_left = int'(amount);
                    m_op   = op;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            checkOutput("model_q", q, m_q);
            checkOutput("model_busy", busy, m_busy);
            checkOutput("model_done", done, m_done);
            checkOutput("model_msb", ser_out_msb, m_q[7]);
            checkOutput("model_lsb", ser_out_lsb, m_q[0]);
        end
    end

    // Drive one request for exactly one posedge; returns at the negedge after that edge.
    task automatic applyStimulus(input logic ld, input logic [7:0] dv, input logic st,
                                 input logic [2:0] o, input logic [3:0] a);
        load   = ld;
        d      = dv;
        start  = st;
        op     = o;
        amount = a;
        @(negedge clock);
        load  = 1'b0;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int exp_busy);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) cnt++;
                @(negedge clock);
            end
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({name, "_busy_cycles"}, cnt, exp_busy);
        @(negedge clock);
        checkOutput({name, "_done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        reset        = 1'b0;
        d            = '0;
        load         = 1'b0;
        start        = 1'b0;
        op           = 3'd0;
        amount       = '0;
        ser_in_left  = 1'b0;
        ser_in_right = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_q", q, 8'h00);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        applyStimulus(1'b1, 8'hA5, 1'b0, 3'd0, 4'd0);
        checkOutput("load_q", q, 8'hA5);
        checkOutput("load_busy", busy, 1'b0);
        checkOutput("load_done", done, 1'b0);

        applyStimulus(1'b1, 8'h81, 1'b0, 3'd0, 4'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 3'd2, 4'd3);
        waitDone("rol3", 3);
        checkOutput("rol3_q", q, 8'h0C);

        applyStimulus(1'b1, 8'h90, 1'b0, 3'd0, 4'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 3'd4, 4'd2);
        waitDone("asr2", 2);
        checkOutput("asr2_q", q, 8'hE4);

        applyStimulus(1'b1, 8'h00, 1'b0, 3'd0, 4'd0);
        ser_in_right = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 3'd0, 4'd4);
        waitDone("shl4", 4);
        checkOutput("shl4_q", q, 8'h0F);
        ser_in_right = 1'b0;

        applyStimulus(1'b1, 8'h5A, 1'b0, 3'd0, 4'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 3'd1, 4'd0);
        checkOutput("amt0_done", done, 1'b1);
        checkOutput("amt0_busy", busy, 1'b0);
        waitDone("amt0", 0);
        checkOutput("amt0_q", q, 8'h5A);

        // A load and a fresh start arrive while the rotate is running; both must be dropped.
        applyStimulus(1'b1, 8'h12, 1'b0, 3'd0, 4'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 3'd2, 4'd2);
        applyStimulus(1'b1, 8'hFF, 1'b1, 3'd1, 4'd7);
        waitDone("lockout", 1);
        checkOutput("lockout_q", q, 8'h48);

        applyStimulus(1'b1, 8'hF0, 1'b0, 3'd0, 4'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 3'd1, 4'd5);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checkOutput("midrst_q", q, 8'h00);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        ser_in_right = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 3'd0, 4'd1);
        waitDone("after_rst", 1);
        checkOutput("after_rst_q", q, 8'h01);
        ser_in_right = 1'b0;

        applyStimulus(1'b1, 8'h3C, 1'b0, 3'd0, 4'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 3'd6, 4'd3);
        waitDone("rsvd", 3);
        checkOutput("rsvd_q", q, 8'h3C);

        applyStimulus(1'b1, 8'h81, 1'b0, 3'd0, 4'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 3'd3, 4'd9);
        waitDone("ror9", 9);
        checkOutput("ror9_q", q, 8'hC0);

        applyStimulus(1'b1, 8'h00, 1'b0, 3'd0, 4'd0);
        ser_in_left = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 3'd1, 4'd10);
        waitDone("shr10", 10);
        checkOutput("shr10_q", q, 8'hFF);
        ser_in_left = 1'b0;

        applyStimulus(1'b1, 8'h80, 1'b0, 3'd0, 4'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 3'd4, 4'd15);
        waitDone("asr15", 15);
        checkOutput("asr15_q", q, 8'hFF);
        checkOutput("asr15_msb", ser_out_msb, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
